sky1_prog_ctrl: RTL and testbench



---
 rtl/sky1_prog_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_sky1_prog_ctrl.sv | 398 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sky1_prog_ctrl.sv
// sky1_prog_ctrl: byte-stream program loader and run/step sequencer for the sky1 core.
// All outputs are flops; the combinational block only decides what they take next edge.
module sky1_prog_ctrl #(
    parameter int MEM_DEPTH   = 19,
    parameter int ADDR_W      = 5,
    parameter int STEP_CYCLES = 3,
    parameter int RST_CYCLES  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              core_we,
    output logic [ADDR_W-1:0] core_addr,
    output logic [7:0]        core_data,
    output logic              core_rst_n,
    output logic              core_en,
    input  logic              core_halted,
    output logic [7:0]        status
);

    localparam logic [7:0] CMD_LOAD   = 8'hA0;
    localparam logic [7:0] CMD_RUN    = 8'hB0;
    localparam logic [7:0] CMD_STEP   = 8'hB1;
    localparam logic [7:0] CMD_STOP   = 8'hB2;
    localparam logic [7:0] CMD_CLRERR = 8'hC0;

    localparam int         TMR_W   = 4;
    localparam logic [7:0] DEPTH_B = 8'(MEM_DEPTH);
    localparam logic [8:0] DEPTH_W = 9'(MEM_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LD_ADDR = 3'd1,
        S_LD_CNT  = 3'd2,
        S_LD_DATA = 3'd3,
        S_RST     = 3'd4,
        S_RUN     = 3'd5,
        S_STEP    = 3'd6
    } state_t;

    state_t            state, state_n;
    logic [ADDR_W-1:0] addr, addr_n;
    logic [7:0]        ld_cnt, ld_cnt_n;
    logic [TMR_W-1:0]  tmr, tmr_n;
    logic              err, err_n;
    logic              done, done_n;
    logic              halted_q;
    logic              we_n;
    logic              accept;
    logic [8:0]        end_addr;

    assign accept   = in_valid && in_ready;
    assign end_addr = 9'(addr) + {1'b0, in_data};
    assign status   = {state != S_IDLE, err, done, halted_q, 1'b0, state};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            addr       <= '0;
            ld_cnt     <= '0;
            tmr        <= '0;
            err        <= 1'b0;
            done       <= 1'b0;
            halted_q   <= 1'b0;
            in_ready   <= 1'b0;
            core_we    <= 1'b0;
            core_addr  <= '0;
            core_data  <= '0;
            core_rst_n <= 1'b0;
            core_en    <= 1'b0;
        end else begin
            state      <= state_n;
            addr       <= addr_n;
            ld_cnt     <= ld_cnt_n;
            tmr        <= tmr_n;
            err        <= err_n;
            done       <= done_n;
            halted_q   <= core_halted;
            in_ready   <= (state_n != S_RST) && (state_n != S_STEP);
            core_rst_n <= (state_n != S_RST);
            core_en    <= (state_n == S_RUN) || (state_n == S_STEP);
            core_we    <= we_n;
            if (we_n) begin
                core_addr <= addr;
                core_data <= in_data;
            end
        end
    end

    always_comb begin
        state_n  = state;
        addr_n   = addr;
        ld_cnt_n = ld_cnt;
        tmr_n    = tmr;
        err_n    = err;
        done_n   = done;
        we_n     = 1'b0;

        unique case (state)
            S_IDLE: begin
                // With err latched, only CLRERR is acted upon; everything else is swallowed.
                if (accept) begin
                    if (err) begin
                        if (in_data == CMD_CLRERR) err_n = 1'b0;
                    end else begin
                        unique case (in_data)
                            CMD_LOAD: begin
                                state_n = S_LD_ADDR;
                                done_n  = 1'b0;
                            end
                            CMD_RUN: begin
                                state_n = S_RST;
                                tmr_n   = TMR_W'(RST_CYCLES - 1);
                                done_n  = 1'b0;
                            end
                            CMD_STEP: begin
                                done_n = 1'b0;
                                if (!core_halted) begin
                                    state_n = S_STEP;
                                    tmr_n   = TMR_W'(STEP_CYCLES - 1);
                                end
                            end
                            CMD_STOP:   ;
                            CMD_CLRERR: err_n = 1'b0;
                            default:    err_n = 1'b1;
                        endcase
                    end
                end
            end
            S_LD_ADDR: begin
                if (accept) begin
                    if (in_data >= DEPTH_B) begin
                        err_n   = 1'b1;
                        state_n = S_IDLE;
                    end else begin
                        addr_n  = in_data[ADDR_W-1:0];
                        state_n = S_LD_CNT;
                    end
                end
            end
            S_LD_CNT: begin
                // The whole range is validated up front so no write can run past the end.
                if (accept) begin
                    if (in_data == 8'd0) begin
                        state_n = S_IDLE;
                    end else if (end_addr > DEPTH_W) begin
                        err_n   = 1'b1;
                        state_n = S_IDLE;
                    end else begin
                        ld_cnt_n = in_data;
                        state_n  = S_LD_DATA;
                    end
                end
            end
            S_LD_DATA: begin
                if (accept) begin
                    we_n     = 1'b1;
                    addr_n   = addr + ADDR_W'(1);
                    ld_cnt_n = ld_cnt - 8'd1;
                    if (ld_cnt == 8'd1) state_n = S_IDLE;
                end
            end
            S_RST: begin
                if (tmr == '0) state_n = S_RUN;
                else           tmr_n   = tmr - TMR_W'(1);
            end
            S_RUN: begin
                // A halt seen together with STOP still counts as a completed run.
                if (core_halted) begin
                    done_n  = 1'b1;
                    state_n = S_IDLE;
                end else if (accept && in_data == CMD_STOP) begin
                    state_n = S_IDLE;
                end
            end
            S_STEP: begin
                if (tmr == '0) state_n = S_IDLE;
                else           tmr_n   = tmr - TMR_W'(1);
            end
            default: state_n = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_sky1_prog_ctrl.sv
// Self-checking bench for sky1_prog_ctrl: table vectors, hand-written run/step/reset
// sequences, and a randomized load stream scored against a transaction-level model.
module tb_sky1_prog_ctrl;

    localparam int MEM_DEPTH = 19;
    localparam int ADDR_W    = 5;

    logic              clk         = 1'b0;
    logic              rst_n       = 1'b0;
    logic [7:0]        in_data     = 8'h00;
    logic              in_valid    = 1'b0;
    logic              core_halted = 1'b0;
    logic              in_ready;
    logic              core_we;
    logic [ADDR_W-1:0] core_addr;
    logic [7:0]        core_data;
    logic              core_rst_n;
    logic              core_en;
    logic [7:0]        status;

    int checks   = 0;
    int failures = 0;

    int cyc              = 0;
    int en_cycles        = 0;
    int rst_low_cycles   = 0;
    int not_ready_cycles = 0;
    int en_ready_cycles  = 0;
    int         wr_cyc_q[$];
    logic [7:0] wr_addr_q[$];
    logic [7:0] wr_data_q[$];

    logic [7:0] core_mem [MEM_DEPTH];
    logic [7:0] exp_mem  [MEM_DEPTH];

    typedef struct {
        logic [7:0] data;
        logic       halted;
        logic [2:0] st;
        logic       err;
        logic       we;
        logic [4:0] waddr;
    } vec_t;

    vec_t tbl[$];

    sky1_prog_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .core_we     (core_we),
        .core_addr   (core_addr),
        .core_data   (core_data),
        .core_rst_n  (core_rst_n),
        .core_en     (core_en),
        .core_halted (core_halted),
        .status      (status)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Models the core's memory and counts output activity just after each edge.
    always @(posedge clk) begin
        #1;
        cyc++;
        if (core_we) begin
            wr_cyc_q.push_back(cyc);
            wr_addr_q.push_back(8'(core_addr));
            wr_data_q.push_back(core_data);
            checkOutput("we_en_exclusive", core_en, 0);
            checkOutput("write_addr_in_range", int'(core_addr) < MEM_DEPTH, 1);
            if (int'(core_addr) < MEM_DEPTH) core_mem[core_addr] = core_data;
        end
        if (core_en)              en_cycles++;
        if (!core_rst_n)          rst_low_cycles++;
        if (!in_ready)            not_ready_cycles++;
        if (core_en && in_ready)  en_ready_cycles++;
    end

    // Called at a negedge; returns at the negedge following the accepting edge.
    task automatic applyStimulus(input logic [7:0] b);
        int guard;
        guard = 0;
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) begin
            checkOutput("in_ready_timeout", in_ready, 1);
            return;
        end
        in_data  = b;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic waitCoreEn();
        int guard;
        guard = 0;
        while (!core_en && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("core_en_rise_timeout", core_en, 1);
    endtask

    task automatic clearCounters();
        en_cycles        = 0;
        rst_low_cycles   = 0;
        not_ready_cycles = 0;
        en_ready_cycles  = 0;
        wr_cyc_q.delete();
        wr_addr_q.delete();
        wr_data_q.delete();
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_in_ready"}, in_ready, 0);
        checkOutput({tag, "_core_we"}, core_we, 0);
        checkOutput({tag, "_core_addr"}, core_addr, 0);
        checkOutput({tag, "_core_data"}, core_data, 0);
        checkOutput({tag, "_core_rst_n"}, core_rst_n, 0);
        checkOutput({tag, "_core_en"}, core_en, 0);
        checkOutput({tag, "_status"}, status, 0);
    endtask

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation still running at time %0t, expected completion", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic       m_err;
        int         kind;
        int         a;
        int         n;
        int         nwr;
        int         exp_writes;
        logic [7:0] b;

        for (int i = 0; i < MEM_DEPTH; i++) begin
            core_mem[i] = 8'h00;
            exp_mem[i]  = 8'h00;
        end

        // Reset values, then the first edge after release.
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checkResetValues("reset");
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("release_core_rst_n", core_rst_n, 1);
        checkOutput("release_in_ready", in_ready, 1);

        // Three back-to-back writes.
        clearCounters();
        applyStimulus(8'hA0);
        applyStimulus(8'h00);
        applyStimulus(8'h03);
        applyStimulus(8'h01);
        applyStimulus(8'h05);
        applyStimulus(8'h0A);
        exp_mem[0] = 8'h01; exp_mem[1] = 8'h05; exp_mem[2] = 8'h0A;
        checkOutput("load3_count", wr_addr_q.size(), 3);
        if (wr_addr_q.size() == 3) begin
            checkOutput("load3_addr0", wr_addr_q[0], 8'h00);
            checkOutput("load3_addr1", wr_addr_q[1], 8'h01);
            checkOutput("load3_addr2", wr_addr_q[2], 8'h02);
            checkOutput("load3_data0", wr_data_q[0], 8'h01);
            checkOutput("load3_data1", wr_data_q[1], 8'h05);
            checkOutput("load3_data2", wr_data_q[2], 8'h0A);
            checkOutput("load3_b2b_1", wr_cyc_q[1] - wr_cyc_q[0], 1);
            checkOutput("load3_b2b_2", wr_cyc_q[2] - wr_cyc_q[1], 1);
        end
        checkOutput("load3_state", status[2:0], 0);
        checkOutput("load3_err", status[6], 0);

        // RUN, core halts after four enabled cycles.
        clearCounters();
        applyStimulus(8'hB0);
        waitCoreEn();
        repeat (3) @(negedge clk);
        core_halted = 1'b1;
        @(negedge clk);
        checkOutput("run_en_after_halt", core_en, 0);
        checkOutput("run_rst_low_cycles", rst_low_cycles, 2);
        checkOutput("run_en_cycles", en_cycles, 4);
        checkOutput("run_done", status[5], 1);
        checkOutput("run_busy", status[7], 0);
        checkOutput("run_state", status[2:0], 0);
        core_halted = 1'b0;

        // Out-of-range load, ignored RUN while err, CLRERR.
        clearCounters();
        applyStimulus(8'hA0);
        checkOutput("bad_load_done_cleared", status[5], 0);
        checkOutput("bad_load_ld_addr", status[2:0], 1);
        applyStimulus(8'h10);
        applyStimulus(8'h04);
        checkOutput("bad_load_err", status[6], 1);
        checkOutput("bad_load_state", status[2:0], 0);
        applyStimulus(8'hB0);
        repeat (3) @(negedge clk);
        checkOutput("bad_load_run_ignored_rst", rst_low_cycles, 0);
        checkOutput("bad_load_run_ignored_en", en_cycles, 0);
        checkOutput("bad_load_still_err", status[6], 1);
        checkOutput("bad_load_no_writes", wr_addr_q.size(), 0);
        applyStimulus(8'hC0);
        checkOutput("clrerr", status[6], 0);

        // Single-byte vectors from IDLE.
        tbl.push_back('{8'hB2, 1'b0, 3'd0, 1'b0, 1'b0, 5'd0});
        tbl.push_back('{8'h55, 1'b0, 3'd0, 1'b1, 1'b0, 5'd0});
        tbl.push_back('{8'hA0, 1'b0, 3'd0, 1'b1, 1'b0, 5'd0});
        tbl.push_back('{8'hB1, 1'b0, 3'd0, 1'b1, 1'b0, 5'd0});
        tbl.push_back('{8'hC0, 1'b0, 3'd0, 1'b0, 1'b0, 5'd0});
        tbl.push_back('{8'hC0, 1'b0, 3'd0, 1'b0, 1'b0, 5'd0});
        tbl.push_back('{8'hA0, 1'b0, 3'd1, 1'b0, 1'b0, 5'd0});
        tbl.push_back('{8'h13, 1'b0, 3'd0, 1'b1, 1'b0, 5'd0});
        tbl.push_back('{8'hC0, 1'b0, 3'd0, 1'b0, 1'b0, 5'd0});
        tbl.push_back('{8'hA0, 1'b0, 3'd1, 1'b0, 1'b0, 5'd0});
        tbl.push_back('{8'h12, 1'b0, 3'd2, 1'b0, 1'b0, 5'd0});
        tbl.push_back('{8'h02, 1'b0, 3'd0, 1'b1, 1'b0, 5'd0});
        tbl.push_back('{8'hC0, 1'b0, 3'd0, 1'b0, 1'b0, 5'd0});
        tbl.push_back('{8'hA0, 1'b0, 3'd1, 1'b0, 1'b0, 5'd0});
        tbl.push_back('{8'h12, 1'b0, 3'd2, 1'b0, 1'b0, 5'd0});
        tbl.push_back('{8'h00, 1'b0, 3'd0, 1'b0, 1'b0, 5'd0});
        tbl.push_back('{8'hA0, 1'b0, 3'd1, 1'b0, 1'b0, 5'd0});
        tbl.push_back('{8'h12, 1'b0, 3'd2, 1'b0, 1'b0, 5'd0});
        tbl.push_back('{8'h01, 1'b0, 3'd3, 1'b0, 1'b0, 5'd0});
        tbl.push_back('{8'h77, 1'b0, 3'd0, 1'b0, 1'b1, 5'd18});
        tbl.push_back('{8'hA0, 1'b0, 3'd1, 1'b0, 1'b0, 5'd0});
        tbl.push_back('{8'h00, 1'b0, 3'd2, 1'b0, 1'b0, 5'd0});
        tbl.push_back('{8'h14, 1'b0, 3'd0, 1'b1, 1'b0, 5'd0});
        tbl.push_back('{8'hC0, 1'b0, 3'd0, 1'b0, 1'b0, 5'd0});
        tbl.push_back('{8'hB1, 1'b1, 3'd0, 1'b0, 1'b0, 5'd0});
        tbl.push_back('{8'hFF, 1'b0, 3'd0, 1'b1, 1'b0, 5'd0});
        tbl.push_back('{8'hC0, 1'b0, 3'd0, 1'b0, 1'b0, 5'd0});
        tbl.push_back('{8'hA0, 1'b0, 3'd1, 1'b0, 1'b0, 5'd0});
        tbl.push_back('{8'h11, 1'b0, 3'd2, 1'b0, 1'b0, 5'd0});
        tbl.push_back('{8'h02, 1'b0, 3'd3, 1'b0, 1'b0, 5'd0});
        tbl.push_back('{8'hC0, 1'b0, 3'd3, 1'b0, 1'b1, 5'd17});
        tbl.push_back('{8'hB0, 1'b0, 3'd0, 1'b0, 1'b1, 5'd18});
        foreach (tbl[i]) begin
            core_halted = tbl[i].halted;
            applyStimulus(tbl[i].data);
            core_halted = 1'b0;
            checkOutput($sformatf("vec%0d_state", i), status[2:0], tbl[i].st);
            checkOutput($sformatf("vec%0d_err", i), status[6], tbl[i].err);
            checkOutput($sformatf("vec%0d_we", i), core_we, tbl[i].we);
            checkOutput($sformatf("vec%0d_en", i), core_en, 0);
            checkOutput($sformatf("vec%0d_ready", i), in_ready, 1);
            if (tbl[i].we) begin
                checkOutput($sformatf("vec%0d_addr", i), core_addr, tbl[i].waddr);
                checkOutput($sformatf("vec%0d_data", i), core_data, tbl[i].data);
                exp_mem[tbl[i].waddr] = tbl[i].data;
            end
        end

        // STEP with the core running, then with it halted.
        clearCounters();
        applyStimulus(8'hB1);
        begin
            int guard;
            guard = 0;
            while (!in_ready && guard < 20) begin
                @(negedge clk);
                guard++;
            end
        end
        checkOutput("step_ready_back", in_ready, 1);
        checkOutput("step_en_cycles", en_cycles, 3);
        checkOutput("step_not_ready_cycles", not_ready_cycles, 3);
        checkOutput("step_en_while_ready", en_ready_cycles, 0);
        checkOutput("step_no_core_reset", rst_low_cycles, 0);
        checkOutput("step_en_after", core_en, 0);
        checkOutput("step_state", status[2:0], 0);
        clearCounters();
        core_halted = 1'b1;
        applyStimulus(8'hB1);
        repeat (4) @(negedge clk);
        core_halted = 1'b0;
        checkOutput("step_halted_no_en", en_cycles, 0);
        checkOutput("step_halted_ready", not_ready_cycles, 0);

        // RUN, ignored byte, then STOP coinciding with halt.
        clearCounters();
        applyStimulus(8'hB0);
        waitCoreEn();
        applyStimulus(8'h55);
        checkOutput("run_ignore_en", core_en, 1);
        checkOutput("run_ignore_err", status[6], 0);
        checkOutput("run_ignore_state", status[2:0], 5);
        repeat (8) @(negedge clk);
        in_data     = 8'hB2;
        in_valid    = 1'b1;
        core_halted = 1'b1;
        @(negedge clk);
        in_valid    = 1'b0;
        core_halted = 1'b0;
        checkOutput("stop_halt_en", core_en, 0);
        checkOutput("stop_halt_done", status[5], 1);
        checkOutput("stop_halt_state", status[2:0], 0);

        // RUN then plain STOP.
        applyStimulus(8'hB0);
        checkOutput("rerun_done_cleared", status[5], 0);
        waitCoreEn();
        repeat (9) @(negedge clk);
        applyStimulus(8'hB2);
        checkOutput("stop_en", core_en, 0);
        checkOutput("stop_done", status[5], 0);
        checkOutput("stop_state", status[2:0], 0);
        checkOutput("stop_ready", in_ready, 1);

        // Asynchronous reset in the middle of a load.
        applyStimulus(8'hA0);
        applyStimulus(8'h05);
        applyStimulus(8'h04);
        applyStimulus(8'h11);
        applyStimulus(8'h22);
        exp_mem[5] = 8'h11; exp_mem[6] = 8'h22;
        checkOutput("midload_state", status[2:0], 3);
        rst_n = 1'b0;
        #1;
        checkResetValues("midload_reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("midload_release_ready", in_ready, 1);
        checkOutput("midload_release_rst_n", core_rst_n, 1);
        checkOutput("midload_release_state", status[2:0], 0);

        // Randomized command stream scored transaction by transaction.
        m_err = 1'b0;
        for (int t = 0; t < 40; t++) begin
            nwr        = wr_addr_q.size();
            exp_writes = 0;
            if (m_err) begin
                if ($urandom_range(0, 2) == 0) begin
                    applyStimulus(8'hC0);
                    m_err = 1'b0;
                end else begin
                    b = 8'($urandom_range(0, 255));
                    if (b == 8'hC0) b = 8'hA0;
                    applyStimulus(b);
                end
            end else begin
                kind = $urandom_range(0, 3);
                if (kind == 0) begin
                    applyStimulus(8'($urandom_range(0, 8'h9F)));
                    m_err = 1'b1;
                end else begin
                    a = $urandom_range(0, 22);
                    n = $urandom_range(0, 7);
                    applyStimulus(8'hA0);
                    applyStimulus(8'(a));
                    if (a >= MEM_DEPTH) begin
                        m_err = 1'b1;
                    end else begin
                        applyStimulus(8'(n));
                        if (n != 0 && a + n > MEM_DEPTH) begin
                            m_err = 1'b1;
                        end else begin
                            for (int i = 0; i < n; i++) begin
                                b = 8'($urandom_range(0, 255));
                                applyStimulus(b);
                                exp_mem[a + i] = b;
                                exp_writes++;
                            end
                        end
                    end
                end
            end
            checkOutput($sformatf("rand%0d_err", t), status[6], m_err);
            checkOutput($sformatf("rand%0d_state", t), status[2:0], 0);
            checkOutput($sformatf("rand%0d_writes", t), wr_addr_q.size() - nwr, exp_writes);
        end
        for (int i = 0; i < MEM_DEPTH; i++)
            checkOutput($sformatf("mem%0d", i), core_mem[i], exp_mem[i]);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
